gs_seed_gen: RTL and testbench

- Upstream stage of the gray-scale XOR block in the LCD main datapath. It generates the 20-bit gray-scale pattern state `gc[19:0]` that the XOR block maps to a 4-bit gray value.
- It keeps a maximal-length 20-bit LFSR with three registers: frame seed, line seed and current pixel state. Frame and line boundaries advance the seeds so the dither pattern varies spatially and temporally.
- Pixel consumption from the downstream pixel pipeline uses an advance/ready handshake.

---
 rtl/gs_seed_gen_pkg.sv | 20 ++
 rtl/gs_seed_gen.sv | 101 ++++++++++
 tb/tb_gs_seed_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gs_seed_gen_pkg.sv
// Shared gray-scale pattern definitions: 20-bit pattern type, LFSR taps and
// step function (x^20 + x^17 + 1), and the seed generator state encoding.
package gs_seed_gen_pkg;

    typedef logic [19:0] gs_state_t;

    localparam int GS_LFSR_TAP_HI = 19;
    localparam int GS_LFSR_TAP_LO = 16;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_RUN   = 2'd1,
        GS_LSTEP = 2'd2
    } gs_fsm_t;

    function automatic gs_state_t gs_lfsr_step(input gs_state_t x);
        return {x[18:0], x[GS_LFSR_TAP_HI] ^ x[GS_LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/gs_seed_gen.sv
// Gray-scale pattern seed generator: frame seed, line seed and per-pixel LFSR
// state feeding the gray-scale XOR block, with an advance/ready pixel handshake.
module gs_seed_gen
    import gs_seed_gen_pkg::*;
#(
    parameter gs_state_t SEED        = 20'h00001,
    parameter int        LINE_STRIDE = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      frame_start,
    input  logic      line_start,
    input  logic      pix_adv,
    output gs_state_t gc,
    output logic      gc_ready,
    output logic      line_busy
);

    if (LINE_STRIDE < 1 || LINE_STRIDE > 15) begin : g_bad_stride
        $error("gs_seed_gen: LINE_STRIDE must be in 1..15");
    end

    localparam logic [3:0] STRIDE_CNT = 4'(LINE_STRIDE);

    gs_fsm_t   r_state, w_state_nxt;
    gs_state_t r_frame_seed, w_frame_seed_nxt;
    gs_state_t r_line_seed, w_line_seed_nxt;
    gs_state_t r_cur, w_cur_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    gs_state_t w_frame_step;
    gs_state_t w_line_step;
    gs_state_t w_cur_step;

    // An all-zero LFSR would lock up; recover to the seed instead.
    function automatic gs_state_t zero_guard(input gs_state_t x);
        return (x == '0) ? SEED : x;
    endfunction

    assign w_frame_step = zero_guard(gs_lfsr_step(r_frame_seed));
    assign w_line_step  = zero_guard(gs_lfsr_step(r_line_seed));
    assign w_cur_step   = zero_guard(gs_lfsr_step(r_cur));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= GS_IDLE;
            r_frame_seed <= SEED;
            r_line_seed  <= SEED;
            r_cur        <= SEED;
            r_cnt        <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_seed <= w_frame_seed_nxt;
            r_line_seed  <= w_line_seed_nxt;
            r_cur        <= w_cur_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_frame_seed_nxt = r_frame_seed;
        w_line_seed_nxt  = r_line_seed;
        w_cur_nxt        = r_cur;
        w_cnt_nxt        = r_cnt;
        if (!en) begin
            w_state_nxt = GS_IDLE;
        end else begin
            case (r_state)
                GS_IDLE: w_state_nxt = GS_RUN;
                GS_RUN, GS_LSTEP: begin
                    // Boundary events outrank pixel advance; a pix_adv alongside them is dropped.
                    if (frame_start) begin
                        w_frame_seed_nxt = w_frame_step;
                        w_line_seed_nxt  = w_frame_step;
                        w_cur_nxt        = w_frame_step;
                        w_state_nxt      = GS_RUN;
                    end else if (line_start) begin
                        w_cnt_nxt   = STRIDE_CNT;
                        w_state_nxt = GS_LSTEP;
                    end else if (r_state == GS_LSTEP) begin
                        w_line_seed_nxt = w_line_step;
                        w_cnt_nxt       = r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            w_cur_nxt   = w_line_step;
                            w_state_nxt = GS_RUN;
                        end
                    end else if (pix_adv) begin
                        w_cur_nxt = w_cur_step;
                    end
                end
                default: w_state_nxt = GS_IDLE;
            endcase
        end
    end

    assign gc        = r_cur;
    assign gc_ready  = (r_state == GS_RUN);
    assign line_busy = (r_state == GS_LSTEP);

endmodule

// File: tb/tb_gs_seed_gen.sv
// Self-checking bench for gs_seed_gen: directed scenarios with fixed expected
// values plus a scoreboard fed by an independent cycle model.
module tb_gs_seed_gen;
    import gs_seed_gen_pkg::*;

    localparam int STRIDE = 3;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      en, frame_start, line_start, pix_adv;
    gs_state_t gc;
    logic      gc_ready, line_busy;

    gs_seed_gen #(.SEED(20'h00001), .LINE_STRIDE(STRIDE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .frame_start(frame_start),
        .line_start (line_start),
        .pix_adv    (pix_adv),
        .gc         (gc),
        .gc_ready   (gc_ready),
        .line_busy  (line_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] gc;
        logic        rdy;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: mode 0 idle, 1 run, 2 line stepping
    int        m_mode;
    int        m_left;
    gs_state_t m_frame, m_line, m_cur;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0;
        m_frame = 20'h00001; m_line = 20'h00001; m_cur = 20'h00001;
        sb_q.delete();
    endtask

    task automatic model_cycle(input logic e, input logic fs, input logic ls, input logic pa);
        exp_t x;
        if (!e) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (fs) begin
            m_frame = gs_lfsr_step(m_frame);
            m_line  = m_frame;
            m_cur   = m_frame;
            m_mode  = 1;
        end else if (ls) begin
            m_mode = 2;
            m_left = STRIDE;
        end else if (m_mode == 2) begin
            m_line = gs_lfsr_step(m_line);
            m_left--;
            if (m_left == 0) begin
                m_cur  = m_line;
                m_mode = 1;
            end
        end else if (pa) m_cur = gs_lfsr_step(m_cur);
        x.gc = m_cur; x.rdy = (m_mode == 1); x.busy = (m_mode == 2);
        sb_q.push_back(x);
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic cyc(input logic e, input logic fs, input logic ls, input logic pa, input string tag);
        exp_t x;
        @(negedge clk);
        en = e; frame_start = fs; line_start = ls; pix_adv = pa;
        model_cycle(e, fs, ls, pa);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            check_val({tag, "_gc"}, 32'(gc), 32'(x.gc));
            check_val({tag, "_rdy"}, 32'(gc_ready), 32'(x.rdy));
            check_val({tag, "_busy"}, 32'(line_busy), 32'(x.busy));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; frame_start = 1'b0; line_start = 1'b0; pix_adv = 1'b0;
        model_reset();
        #12;
        check_val("rst_gc", 32'(gc), 32'h00001);
        check_val("rst_rdy", 32'(gc_ready), 32'd0);
        check_val("rst_busy", 32'(line_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Enable: ready after two cycles, gc still the seed
        cyc(1, 0, 0, 0, "en1");
        cyc(1, 0, 0, 0, "en2");
        check_val("en_gc", 32'(gc), 32'h00001);
        check_val("en_rdy", 32'(gc_ready), 32'd1);

        // Pixel advance walks a single bit up, then the tap feeds back
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 0, 0, 1, "pix");
            check_val($sformatf("pix%0d", k), 32'(gc), 32'h1 << k);
        end
        cyc(1, 0, 0, 1, "pix17");
        check_val("pix17_gc", 32'(gc), 32'h20001);

        // Line step from line seed 1: busy for exactly 3 cycles, pix_adv ignored
        cyc(1, 0, 1, 0, "ls");
        for (int k = 0; k < STRIDE; k++) begin
            check_val($sformatf("ls_busy%0d", k), 32'(line_busy), 32'd1);
            check_val($sformatf("ls_rdy%0d", k), 32'(gc_ready), 32'd0);
            check_val($sformatf("ls_gc_hold%0d", k), 32'(gc), 32'h20001);
            cyc(1, 0, 0, 1, "ls_step");
        end
        check_val("ls_gc", 32'(gc), 32'h00008);
        check_val("ls_done_rdy", 32'(gc_ready), 32'd1);

        // Frame start in the second LSTEP cycle aborts the line step
        cyc(1, 0, 1, 0, "ls2");
        cyc(1, 0, 0, 0, "ls2_a");
        cyc(1, 1, 0, 0, "fs_abort");
        check_val("fs_abort_gc", 32'(gc), 32'h00002);
        check_val("fs_abort_rdy", 32'(gc_ready), 32'd1);
        check_val("fs_abort_busy", 32'(line_busy), 32'd0);

        // All three events together: frame behaviour only
        cyc(1, 1, 1, 1, "all3");
        check_val("all3_gc", 32'(gc), 32'h00004);
        check_val("all3_busy", 32'(line_busy), 32'd0);
        cyc(1, 0, 0, 0, "all3_after");
        check_val("all3_after_busy", 32'(line_busy), 32'd0);

        // Asynchronous reset between clock edges during LSTEP
        cyc(1, 0, 1, 0, "ls3");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_gc", 32'(gc), 32'h00001);
        check_val("arst_rdy", 32'(gc_ready), 32'd0);
        check_val("arst_busy", 32'(line_busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Dropping en mid-LSTEP holds cur and leaves the line seed partly stepped
        cyc(1, 0, 0, 0, "en_b");
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 1, "pix_b");
        check_val("pix_b_gc", 32'(gc), 32'h00008);
        cyc(1, 0, 1, 0, "ls4");
        cyc(1, 0, 0, 0, "ls4_step");
        cyc(0, 0, 0, 0, "endrop");
        check_val("endrop_gc", 32'(gc), 32'h00008);
        check_val("endrop_rdy", 32'(gc_ready), 32'd0);
        check_val("endrop_busy", 32'(line_busy), 32'd0);
        cyc(1, 0, 0, 0, "reen");
        cyc(1, 0, 1, 0, "ls5");
        for (int k = 0; k < STRIDE; k++) cyc(1, 0, 0, 0, "ls5_step");
        check_val("ls5_gc", 32'(gc), 32'h00010);

        // Random traffic against the model, including repeated line_start
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
